// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit:
// operation codes, FSM state encoding and op-class helpers.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic is_mdu_start(input logic [3:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

  function automatic logic is_mdu_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage MDU bus: operation code and forwarded operands in,
// handshake flags, read-back mux and HI/LO trace out.
interface e_mdu_if;
  logic [3:0]  MDUOp_E;
  logic [31:0] V1_E;
  logic [31:0] V2_E;
  logic        Start;
  logic        Busy;
  logic [31:0] MDUOut;
  logic [31:0] HI_o;
  logic [31:0] LO_o;

  modport master (
    output MDUOp_E, V1_E, V2_E,
    input  Start, Busy, MDUOut, HI_o, LO_o
  );

  modport slave (
    input  MDUOp_E, V1_E, V2_E,
    output Start, Busy, MDUOut, HI_o, LO_o
  );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: result computed at the start edge, held in
// res_hi/res_lo, and committed to HI/LO when the busy down-counter expires.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic    clk,
  input  logic    reset,
  e_mdu_if.slave  bus
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [31:0]       hi, lo;
  logic [31:0]       res_hi, res_lo;
  logic              res_valid;
  logic [31:0]       calc_hi, calc_lo;
  logic              calc_valid;
  logic              start, load_res, commit;

  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;

  assign start = is_mdu_start(bus.MDUOp_E) && (state == ST_IDLE);

  // A zero divisor yields calc_valid=0 so the commit leaves HI/LO untouched.
  always_comb begin
    prod_s     = {{32{bus.V1_E[31]}}, bus.V1_E} * {{32{bus.V2_E[31]}}, bus.V2_E};
    prod_u     = {32'b0, bus.V1_E} * {32'b0, bus.V2_E};
    quot_s     = '0;
    rem_s      = '0;
    quot_u     = '0;
    rem_u      = '0;
    calc_hi    = '0;
    calc_lo    = '0;
    calc_valid = 1'b0;
    if (bus.V2_E != 32'b0) begin
      quot_s = $signed(bus.V1_E) / $signed(bus.V2_E);
      rem_s  = $signed(bus.V1_E) % $signed(bus.V2_E);
      quot_u = bus.V1_E / bus.V2_E;
      rem_u  = bus.V1_E % bus.V2_E;
    end
    case (bus.MDUOp_E)
      MDU_MULT: begin
        calc_hi    = prod_s[63:32];
        calc_lo    = prod_s[31:0];
        calc_valid = 1'b1;
      end
      MDU_MULTU: begin
        calc_hi    = prod_u[63:32];
        calc_lo    = prod_u[31:0];
        calc_valid = 1'b1;
      end
      MDU_DIV: begin
        calc_hi    = rem_s;
        calc_lo    = quot_s;
        calc_valid = (bus.V2_E != 32'b0);
      end
      MDU_DIVU: begin
        calc_hi    = rem_u;
        calc_lo    = quot_u;
        calc_valid = (bus.V2_E != 32'b0);
      end
      default: begin
        calc_valid = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_res   = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_res   = 1'b1;
          cnt_next   = is_mdu_div(bus.MDUOp_E) ? DIV_LOAD : MULT_LOAD;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_next = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          commit     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Reset also drops the pending result so an aborted op can never commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi        <= '0;
      lo        <= '0;
      res_hi    <= '0;
      res_lo    <= '0;
      res_valid <= 1'b0;
    end else begin
      if (load_res) begin
        res_hi    <= calc_hi;
        res_lo    <= calc_lo;
        res_valid <= calc_valid;
      end
      if (commit && res_valid) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == ST_IDLE) begin
        if (bus.MDUOp_E == MDU_MTHI) hi <= bus.V1_E;
        if (bus.MDUOp_E == MDU_MTLO) lo <= bus.V1_E;
      end
    end
  end

  assign bus.Start  = start;
  assign bus.Busy   = (state == ST_BUSY);
  assign bus.MDUOut = (bus.MDUOp_E == MDU_MFHI) ? hi :
                      (bus.MDUOp_E == MDU_MFLO) ? lo : 32'b0;
  assign bus.HI_o   = hi;
  assign bus.LO_o   = lo;

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: table of mult/div vectors through a result scoreboard,
// plus hand sequences for mthi/mtlo, divide by zero, reset abort and ignored ops.
module tb_e_mdu;
  import mdu_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    bit          peek_lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_hi = 32'b0;
  logic [31:0] model_lo = 32'b0;
  res_t        sb[$];
  vec_t        vecs[10];

  e_mdu_if bus();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2);
    @(negedge clk);
    bus.MDUOp_E = op;
    bus.V1_E    = v1;
    bus.V2_E    = v2;
    #1;
  endtask

  // Issues one mult/div op, counts busy cycles and checks the committed result.
  task automatic run_op(input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int cycles, input bit peek_lo, input bit force_busy);
    res_t r;
    res_t got;
    int   n;
    apply_stimulus(op, v1, v2);
    check_output("start_pulse", {31'b0, bus.Start}, 32'd1);
    r.hi = exp_hi;
    r.lo = exp_lo;
    sb.push_back(r);
    @(negedge clk);
    bus.MDUOp_E = force_busy ? MDU_MULT : MDU_NONE;
    bus.V1_E    = 32'h0000_0007;
    bus.V2_E    = 32'h0000_0009;
    #1;
    n = 0;
    while (bus.Busy === 1'b1 && n < 64) begin
      if (n == 0 && peek_lo) begin
        bus.MDUOp_E = MDU_MFLO;
        #1;
        check_output("mflo_while_busy", bus.MDUOut, model_lo);
        bus.MDUOp_E = MDU_NONE;
        #1;
      end
      if (force_busy) check_output("start_while_busy", {31'b0, bus.Start}, 32'd0);
      n++;
      @(negedge clk);
      #1;
    end
    bus.MDUOp_E = MDU_NONE;
    check_output("busy_cycles", n, cycles);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check_output("hi_commit", bus.HI_o, got.hi);
      check_output("lo_commit", bus.LO_o, got.lo);
    end else begin
      check_output("scoreboard_empty", 32'd0, 32'd1);
    end
    model_hi = exp_hi;
    model_lo = exp_lo;
    bus.MDUOp_E = MDU_MFHI;
    #1;
    check_output("mfhi", bus.MDUOut, model_hi);
    bus.MDUOp_E = MDU_MFLO;
    #1;
    check_output("mflo", bus.MDUOut, model_lo);
    bus.MDUOp_E = MDU_NONE;
  endtask

  initial begin
    int watch_busy;
    int changed;

    vecs[0] = '{MDU_MULT,  32'hFFFFFFFD, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFA, 5,  1'b0};
    vecs[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5,  1'b1};
    vecs[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0};
    vecs[3] = '{MDU_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10, 1'b0};
    vecs[4] = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5,  1'b0};
    vecs[5] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5,  1'b1};
    vecs[6] = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, 1'b0};
    vecs[7] = '{MDU_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 10, 1'b0};
    vecs[8] = '{MDU_DIVU,  32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 10, 1'b0};
    vecs[9] = '{MDU_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5,  1'b0};

    reset       = 1'b1;
    bus.MDUOp_E = MDU_NONE;
    bus.V1_E    = 32'b0;
    bus.V2_E    = 32'b0;
    repeat (2) @(negedge clk);
    #1;
    check_output("reset_busy",   {31'b0, bus.Busy},  32'd0);
    check_output("reset_start",  {31'b0, bus.Start}, 32'd0);
    check_output("reset_mduout", bus.MDUOut, 32'd0);
    check_output("reset_hi",     bus.HI_o, 32'd0);
    check_output("reset_lo",     bus.LO_o, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].v1, vecs[i].v2, vecs[i].hi, vecs[i].lo,
             vecs[i].cycles, vecs[i].peek_lo, 1'b0);
    end

    apply_stimulus(MDU_MTHI, 32'h12345678, 32'h0);
    apply_stimulus(MDU_MTLO, 32'h0BADF00D, 32'h0);
    check_output("mthi", bus.HI_o, 32'h12345678);
    apply_stimulus(MDU_NONE, 32'h0, 32'h0);
    check_output("mtlo", bus.LO_o, 32'h0BADF00D);
    model_hi = 32'h12345678;
    model_lo = 32'h0BADF00D;

    apply_stimulus(4'd9, 32'hFFFFFFFF, 32'h1);
    check_output("unknown_start",  {31'b0, bus.Start}, 32'd0);
    check_output("unknown_mduout", bus.MDUOut, 32'd0);
    apply_stimulus(MDU_NONE, 32'h0, 32'h0);
    check_output("unknown_hi", bus.HI_o, model_hi);
    check_output("unknown_lo", bus.LO_o, model_lo);

    run_op(MDU_DIVU, 32'h00000005, 32'h0, model_hi, model_lo, 10, 1'b0, 1'b0);
    run_op(MDU_DIV,  32'hFFFFFFF0, 32'h0, model_hi, model_lo, 10, 1'b0, 1'b0);

    run_op(MDU_MULT, 32'hFFFFFFFD, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 1'b0, 1'b1);

    apply_stimulus(MDU_MULT, 32'h00000003, 32'h00000003);
    apply_stimulus(MDU_NONE, 32'h0, 32'h0);
    check_output("abort_busy_c1", {31'b0, bus.Busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_output("abort_busy", {31'b0, bus.Busy}, 32'd0);
    check_output("abort_hi",   bus.HI_o, 32'd0);
    check_output("abort_lo",   bus.LO_o, 32'd0);
    reset      = 1'b0;
    watch_busy = 0;
    changed    = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (bus.Busy !== 1'b0) watch_busy++;
      if (bus.HI_o !== 32'd0 || bus.LO_o !== 32'd0) changed++;
    end
    check_output("no_late_busy",   watch_busy, 32'd0);
    check_output("no_late_commit", changed, 32'd0);
    check_output("scoreboard_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
